// File: rtl/mem_arbiter.sv
// mem_arbiter: shared main-memory controller for the I-side fill path and the
// D-side fill/write-through path.  It sequences BLOCK_WORDS-word block fills
// over a pipelined memory port (MEM_LAT cycles from mem_en to mem_rvalid) and
// single-word writes.  After reset it spends MEM_LAT cycles in DRAIN so that
// returns from an aborted fill are swallowed.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN  - ties go to the side not served most recently
//                         (undefined: the D-side always wins a tie).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   i_req, i_addr              I-side fill request / byte address
//   d_req, d_wr, d_addr,
//   d_wdata                    D-side request, 1=write 0=fill, address, data
//   i_grant, d_grant           pulse on the first serviced cycle
//   i_done, d_done             pulse on the last serviced cycle
//   fill_data, fill_valid,
//   fill_word, fill_sel        returning fill word, index, target (1=D)
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                  memory request port
//   mem_rdata, mem_rvalid      memory return port
//   busy                       high whenever the controller is not IDLE
module mem_arbiter #(
  parameter int MEM_LAT     = 4,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req,
  input  logic [15:0]                    i_addr,
  input  logic                           d_req,
  input  logic                           d_wr,
  input  logic [15:0]                    d_addr,
  input  logic [15:0]                    d_wdata,
  output logic                           i_grant,
  output logic                           d_grant,
  output logic                           i_done,
  output logic                           d_done,
  output logic [15:0]                    fill_data,
  output logic                           fill_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           fill_sel,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata,
  input  logic                           mem_rvalid,
  output logic                           busy
);

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int DW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [WW:0]   ISSUE_END  = (WW+1)'(BLOCK_WORDS);
  localparam logic [WW-1:0] RET_LAST   = WW'(BLOCK_WORDS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MEM_LAT - 1);
  localparam logic [15:0]   BLK_MASK   = 16'(2 * BLOCK_WORDS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state;
  logic          sel;       // 0 = I-side owns the current transaction
  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          first_q;   // first cycle of a fill (grant cycle)
  logic [WW:0]   issue_cnt;
  logic [WW-1:0] ret_cnt;
  logic [DW-1:0] drain_cnt;
  logic          pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_served;        // 0 = I-side served most recently

  always_comb begin
    pick_d = d_req && !(i_req && last_served);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_served <= 1'b0;
    end else if (state == IDLE && (i_req || d_req)) begin
      last_served <= pick_d;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DRAIN;
      sel       <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      first_q   <= 1'b0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            sel       <= pick_d;
            addr_q    <= pick_d ? d_addr : i_addr;
            wdata_q   <= d_wdata;
            first_q   <= 1'b1;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            state     <= (pick_d && d_wr) ? WRITE : FILL;
          end
        end
        FILL: begin
          first_q <= 1'b0;
          if (issue_cnt != ISSUE_END) begin
            issue_cnt <= issue_cnt + (WW+1)'(1);
          end
          if (mem_rvalid) begin
            ret_cnt <= ret_cnt + WW'(1);
            if (ret_cnt == RET_LAST) begin
              state <= IDLE;
            end
          end
        end
        WRITE: begin
          first_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          // DRAIN: wait out every read that may still be in flight
          if (drain_cnt == DRAIN_LAST) begin
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
      endcase
    end
  end

  logic in_fill;
  logic in_write;
  logic issuing;
  logic last_ret;
  logic grant_pulse;
  logic done_pulse;

  always_comb begin
    in_fill     = (state == FILL);
    in_write    = (state == WRITE);
    issuing     = in_fill && (issue_cnt != ISSUE_END);
    // Returns are only honoured in FILL; strays elsewhere are dropped here.
    fill_valid  = in_fill && mem_rvalid;
    last_ret    = fill_valid && (ret_cnt == RET_LAST);
    grant_pulse = (in_fill && first_q) || in_write;
    done_pulse  = last_ret || in_write;

    busy      = (state != IDLE);
    i_grant   = grant_pulse && !sel;
    d_grant   = grant_pulse && sel;
    i_done    = done_pulse && !sel;
    d_done    = done_pulse && sel;
    fill_data = fill_valid ? mem_rdata : '0;
    fill_word = fill_valid ? ret_cnt : '0;
    fill_sel  = fill_valid && sel;

    mem_en    = issuing || in_write;
    mem_wr    = in_write;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issuing) begin
      mem_addr = (addr_q & ~BLK_MASK) + 16'({issue_cnt[WW-1:0], 1'b0});
    end else if (in_write) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations followed by randomized requesters, stray returns and resets.
// A transaction-level model schedules the expected per-cycle outputs of each
// granted transaction from the timing rules; a pipelined memory model answers
// every read exactly MEM_LAT cycles later.
module tb_mem_arbiter;
  localparam int LAT = 4;
  localparam int BW  = 8;

  logic        clk;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, d_grant, i_done, d_done;
  logic [15:0] fill_data;
  logic        fill_valid;
  logic [2:0]  fill_word;
  logic        fill_sel;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        busy;

  mem_arbiter #(.MEM_LAT(LAT), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant), .i_done(i_done), .d_done(d_done),
    .fill_data(fill_data), .fill_valid(fill_valid), .fill_word(fill_word),
    .fill_sel(fill_sel),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        men, mwr;
    logic [15:0] maddr, mwdata;
    logic        fv;
    logic [15:0] fd;
    logic [2:0]  fw;
    logic        fs, ig, dg, idn, ddn;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  exp_t        sched [int];
  logic [15:0] ret_q [int];
  int          free_at = 1 + LAT;
  int          last_rst = 0;
  int          fill_lo = 0;
  int          fill_hi = -1;
  int          i_done_at = -1;
  int          d_done_at = -1;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_d = 1'b0;
`endif

  // shadow stimulus, applied just after each rising edge
  logic        s_rst = 1'b1;
  logic        s_i = 1'b0, s_d = 1'b0, s_dwr = 1'b0;
  logic [15:0] s_ia = '0, s_da = '0, s_dw = '0;
  logic        stray_en = 1'b0;
  logic        force_rv = 1'b0;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  function automatic exp_t get_e(input int t);
    if (sched.exists(t)) return sched[t];
    return '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  task automatic sched_fill(input int c, input logic sd, input logic [15:0] a);
    logic [15:0] base;
    exp_t e;
    int g;
    base = a & ~16'(2 * BW - 1);
    g = c + 1;
    for (int k = 0; k < BW; k++) begin
      e = get_e(g + k);
      e.men = 1'b1;
      e.maddr = base + 16'(2 * k);
      sched[g + k] = e;
    end
    for (int k = 0; k < BW; k++) begin
      e = get_e(g + LAT + k);
      e.fv = 1'b1;
      e.fd = mem_f(base + 16'(2 * k));
      e.fw = 3'(k);
      e.fs = sd;
      sched[g + LAT + k] = e;
    end
    e = get_e(g);
    if (sd) e.dg = 1'b1; else e.ig = 1'b1;
    sched[g] = e;
    e = get_e(g + LAT + BW - 1);
    if (sd) e.ddn = 1'b1; else e.idn = 1'b1;
    sched[g + LAT + BW - 1] = e;
    free_at = g + LAT + BW;
    fill_lo = g;
    fill_hi = g + LAT + BW - 1;
    if (sd) d_done_at = g + LAT + BW - 1; else i_done_at = g + LAT + BW - 1;
  endtask

  task automatic sched_write(input int c, input logic [15:0] a, input logic [15:0] w);
    exp_t e;
    e = get_e(c + 1);
    e.men = 1'b1; e.mwr = 1'b1; e.maddr = a; e.mwdata = w;
    e.dg = 1'b1; e.ddn = 1'b1;
    sched[c + 1] = e;
    free_at = c + 2;
    d_done_at = c + 1;
  endtask

  // compare + model update, once per cycle away from the sampling edge
  always @(negedge clk) begin : cmp_p
    int n;
    exp_t e;
    logic drain;
    logic win_d;
    n = cyc;
    if (n >= 1) begin
      e = get_e(n);
      drain = (n - last_rst >= 1) && (n - last_rst <= LAT);
      chk("busy", busy, n < free_at);
      chk("mem_en", mem_en, e.men);
      if (e.men || drain) begin
        chk("mem_wr", mem_wr, e.mwr);
        chk("mem_addr", mem_addr, e.maddr);
        if (e.mwr || drain) chk("mem_wdata", mem_wdata, e.mwdata);
      end
      chk("fill_valid", fill_valid, e.fv);
      if (e.fv || drain) begin
        chk("fill_data", fill_data, e.fd);
        chk("fill_word", fill_word, e.fw);
        chk("fill_sel", fill_sel, e.fs);
      end
      chk("i_grant", i_grant, e.ig);
      chk("d_grant", d_grant, e.dg);
      chk("i_done", i_done, e.idn);
      chk("d_done", d_done, e.ddn);
      if (sched.exists(n)) sched.delete(n);

      if (mem_en && !mem_wr) ret_q[n + LAT] = mem_f(mem_addr);

      if (rst) begin
        for (int k = n + 1; k <= n + BW + LAT + 2; k++)
          if (sched.exists(k)) sched.delete(k);
        free_at = n + 1 + LAT;
        last_rst = n;
        if (fill_hi > n) fill_hi = n;
        if (i_done_at > n) i_done_at = -1;
        if (d_done_at > n) d_done_at = -1;
`ifdef ARB_ROUND_ROBIN_EN
        last_d = 1'b0;
`endif
      end else if (n >= free_at && (i_req || d_req)) begin
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          win_d = !last_d;
`else
          win_d = 1'b1;
`endif
        end else begin
          win_d = d_req;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_d = win_d;
`endif
        if (win_d && d_wr) sched_write(n, d_addr, d_wdata);
        else sched_fill(n, win_d, win_d ? d_addr : i_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst = s_rst;
    i_req = s_i; i_addr = s_ia;
    d_req = s_d; d_wr = s_dwr; d_addr = s_da; d_wdata = s_dw;
    if (ret_q.exists(cyc)) begin
      mem_rvalid = 1'b1;
      mem_rdata = ret_q[cyc];
      ret_q.delete(cyc);
    end else if (force_rv ||
                 (stray_en && !(cyc >= fill_lo && cyc <= fill_hi) && ($urandom % 4 == 0))) begin
      mem_rvalid = 1'b1;
      mem_rdata = 16'($urandom);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata = 16'($urandom);
    end
    force_rv = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic serve_all(input int ncyc);
    repeat (ncyc) begin
      if (s_i && cyc == i_done_at) s_i = 1'b0;
      if (s_d && cyc == d_done_at) s_d = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_rvalid = 1'b0;

    // power-on reset, then DRAIN
    tick();
    chk("rst_busy", busy, 1);
    chk("rst_mem_en", mem_en, 0);
    repeat (2) tick();
    s_rst = 1'b0;
    repeat (5) tick();
    chk("idle_after_drain", busy, 0);

    // I fill alone
    s_i = 1'b1; s_ia = 16'h1234;
    tick();
    for (int t = 1; t <= 13; t++) begin
      if (t == 13) s_i = 1'b0;
      tick();
      if (t == 1) chk("A_i_grant", i_grant, 1);
      if (t <= 8) chk("A_mem_addr", mem_addr, 16'h1230 + 16'(2 * (t - 1)));
      if (t == 9) chk("A_mem_en_off", mem_en, 0);
      if (t >= 5 && t <= 12) begin
        chk("A_fill_valid", fill_valid, 1);
        chk("A_fill_word", fill_word, t - 5);
        chk("A_fill_sel", fill_sel, 0);
      end
      if (t == 12) chk("A_i_done", i_done, 1);
      if (t == 13) chk("A_busy_low", busy, 0);
    end

    // D write with stray returns in WRITE and IDLE
    s_d = 1'b1; s_dwr = 1'b1; s_da = 16'h0040; s_dw = 16'hBEEF;
    tick();
    force_rv = 1'b1;
    tick();
    chk("B_mem_en", mem_en, 1);
    chk("B_mem_wr", mem_wr, 1);
    chk("B_mem_addr", mem_addr, 16'h0040);
    chk("B_mem_wdata", mem_wdata, 16'hBEEF);
    chk("B_d_grant", d_grant, 1);
    chk("B_d_done", d_done, 1);
    chk("B_no_fill", fill_valid, 0);
    s_d = 1'b0; s_dwr = 1'b0; force_rv = 1'b1;
    tick();
    chk("B_idle_stray", fill_valid, 0);
    chk("B_busy_low", busy, 0);
    tick();

    // reset in cycle 6 of an I fill; request stays held
    s_i = 1'b1; s_ia = 16'h5678;
    tick();
    repeat (5) tick();
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    tick();
    chk("R_busy", busy, 1);
    chk("R_mem_en", mem_en, 0);
    chk("R_fill_valid", fill_valid, 0);
    chk("R_i_grant", i_grant, 0);
    repeat (3) begin
      tick();
      chk("R_drain_drop", fill_valid, 0);
    end
    tick();
    chk("R_idle", busy, 0);
    tick();
    chk("R_regrant", i_grant, 1);
    chk("R_regrant_addr", mem_addr, 16'h5670);
    serve_all(13);

    // tie: D first, I granted in cycle 14
    s_i = 1'b1; s_ia = 16'h2000;
    s_d = 1'b1; s_dwr = 1'b0; s_da = 16'h0100;
    tick();
    for (int t = 1; t <= 14; t++) begin
      if (t == 13) s_d = 1'b0;
      tick();
      if (t == 1) begin
        chk("C_d_grant", d_grant, 1);
        chk("C_i_grant_held", i_grant, 0);
        chk("C_addr0", mem_addr, 16'h0100);
      end
      if (t == 5) chk("C_fill_sel", fill_sel, 1);
      if (t == 8) chk("C_addr7", mem_addr, 16'h010E);
      if (t == 12) chk("C_d_done", d_done, 1);
      if (t == 14) begin
        chk("C_i_grant", i_grant, 1);
        chk("C_i_addr", mem_addr, 16'h2000);
      end
    end
    serve_all(14);

    // D write alone, then a second tie
    s_d = 1'b1; s_dwr = 1'b1; s_da = 16'h0200; s_dw = 16'h1111;
    tick();
    tick();
    s_d = 1'b0; s_dwr = 1'b0;
    tick();
    s_i = 1'b1; s_ia = 16'h3000;
    s_d = 1'b1; s_da = 16'h0300;
    tick();
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("T2_i_first", i_grant, 1);
    chk("T2_addr", mem_addr, 16'h3000);
`else
    chk("T2_d_first", d_grant, 1);
    chk("T2_addr", mem_addr, 16'h0300);
`endif
    serve_all(30);

    // back-to-back D fills, new request in cycle 13
    s_d = 1'b1; s_dwr = 1'b0; s_da = 16'h3456;
    tick();
    repeat (12) tick();
    chk("E_d_done", d_done, 1);
    s_da = 16'h4802;
    tick();
    chk("E_idle", busy, 0);
    tick();
    chk("E_d_grant", d_grant, 1);
    chk("E_base", mem_addr, 16'h4800);
    serve_all(14);

    // randomized traffic
    stray_en = 1'b1;
    repeat (3000) begin
      if (s_i && cyc == i_done_at) s_i = 1'b0;
      else if (!s_i && ($urandom % 5 == 0)) begin
        s_i = 1'b1; s_ia = 16'($urandom);
      end
      if (s_d && cyc == d_done_at) s_d = 1'b0;
      else if (!s_d && ($urandom % 5 == 0)) begin
        s_d = 1'b1; s_dwr = 1'($urandom % 2);
        s_da = 16'($urandom); s_dw = 16'($urandom);
      end
      s_rst = ($urandom % 250 == 0) || (s_rst && ($urandom % 2 == 0));
      tick();
    end
    s_rst = 1'b0; s_i = 1'b0; s_d = 1'b0;
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-cycle main-memory controller that serves two requesters over one shared, pipelined main-memory port: the instruction-fetch cache miss path (I-side) and the MEM-stage data cache miss/write path (D-side). It sequences 8-word block fills and single-word write-through stores. It arbitrates simultaneous requests and holds off requesters while the memory is busy. It sits between both cache controllers and the main-memory model.

## Interface
- MEM_LAT, 4, cycles from address presented (mem_en=1) to matching mem_rvalid
- BLOCK_WORDS, 8, 16-bit words per fill (power of two)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-side fill request; held high until i_done
- i_addr  in  16  I-side byte address (any byte within the block)
- d_req  in  1  D-side request; held high until d_done
- d_wr  in  1  D-side 1=single-word write, 0=block fill
- d_addr  in  16  D-side byte address
- d_wdata  in  16  D-side write data
- i_grant / d_grant  out  1  one-cycle pulse on first serviced cycle
- i_done / d_done  out  1  one-cycle pulse on the last serviced cycle
- fill_data  out  16  returning fill word
- fill_valid  out  1  fill_data valid this cycle
- fill_word  out  3  word index within block of fill_data
- fill_sel  out  1  0=fill targets I-side, 1=D-side
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  1=write, valid with mem_en
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rvalid  in  1  mem_rdata valid
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, FILL, WRITE, DRAIN.
- IDLE: sample requests at the clock edge. No request keeps IDLE. A winner's address, d_wr and data are latched at that edge.
- The D-side wins when both requesters are pending (see Configuration).
- FILL: base = addr & ~(2*BLOCK_WORDS-1).
  - Issue counter k=0..BLOCK_WORDS-1 drives mem_en=1, mem_wr=0, mem_addr=base+2k, one word per cycle.
  - Return counter increments on each mem_rvalid. Each return drives fill_valid=1 with fill_data=mem_rdata, fill_word=return count, and fill_sel set to the granted side.
  - The requester's done pulse coincides with the last return. The next state is IDLE.
- WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=latched d_addr, mem_wdata=latched d_wdata. d_done pulses in the same cycle. The next state is IDLE.
- I-side never writes, so i_req is always a fill.
- mem_rvalid outside FILL is ignored and produces no fill_valid.
- Address arithmetic is 16-bit unsigned. Block alignment guarantees no wrap inside a block.
- Requesters must deassert req in the cycle after their done pulse. In the cycle after done, the controller is in IDLE and samples req afresh.

## Timing
- Reset:
  - State becomes DRAIN and all counters clear.
  - All outputs go to 0 except busy=1.
  - DRAIN lasts MEM_LAT cycles and discards any mem_rvalid, so in-flight reads from an aborted fill are dropped. It then enters IDLE.
  - Reset during any state, including mid-fill, behaves identically.
- Cycle numbering for a fill: req is sampled high at the end of cycle 0.
  - Cycle 1: grant=1, first mem_en.
  - Cycles 1..BLOCK_WORDS: issue.
  - Cycles 1+MEM_LAT .. BLOCK_WORDS+MEM_LAT: returns. With defaults, returns occur in cycles 5..12 and done in cycle 12.
  - Cycle 13: IDLE.
  - Earliest next grant is cycle 14.
- Write: grant and done both in cycle 1, IDLE in cycle 2, next grant no earlier than cycle 3.
- Grant and done are never asserted for both sides in the same cycle.
- busy=1 from the grant cycle through the done cycle.

## Configuration
- ARB_ROUND_ROBIN_EN undefined: fixed priority, D-side always wins a tie.
- ARB_ROUND_ROBIN_EN defined: a last_served bit records the side granted most recently.
  - On a tie, the side not last served wins.
  - Reset sets last_served=I, so the first tie goes to D.
  - Non-tie grants also update last_served.

## Test plan
- I fill alone: i_addr=0x1234 → base 0x1230, mem_addr 0x1230..0x123E in cycles 1–8, fill_valid cycles 5–12 with fill_word 0..7, fill_sel=0, i_done cycle 12, busy low cycle 13.
- D write: d_req=1, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF → cycle 1 mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_grant=d_done=1, no fill_valid.
- Tie: i_req (0x2000) and d_req read (0x0100) together, both held → D fill first (fill_sel=1, addr 0x0100..0x010E), i_grant cycle 14. With ARB_ROUND_ROBIN_EN and a second tie, I is served first.
- Reset mid-fill: rst high in cycle 6 of an I fill → next cycle all outputs 0, busy=1. mem_rvalid pulses over the following 4 cycles produce no fill_valid. A new i_req is granted only after DRAIN ends.
- Stray mem_rvalid while IDLE or WRITE → no fill_valid, state unchanged.
- Back-to-back D fills with d_req reasserted in cycle 13 → second d_grant in cycle 14, first mem_addr equal to the new block base.
